// File: rtl/ws2812_pkg.sv
// ============================================================================
// Module : ws2812_pkg
// Shared types and defaults for the WS2812 transmitter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ws2812_pkg;

  localparam int PIXEL_W = 24;

  localparam int DEF_T0H_CYC    = 16;
  localparam int DEF_T1H_CYC    = 34;
  localparam int DEF_TBIT_CYC   = 60;
  localparam int DEF_TRST_CYC   = 14400;
  localparam int DEF_FIFO_DEPTH = 16;

  // Status word byte lanes: {ovf_cnt, fifo_level, frame_cnt}
  localparam int STAT_FRM_LSB = 0;
  localparam int STAT_LVL_LSB = 8;
  localparam int STAT_OVF_LSB = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_LATCH = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ws2812_fifo.sv
// ============================================================================
// Module : ws2812_fifo
// Show-ahead synchronous FIFO; a full FIFO accepts a push only alongside a pop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ws2812_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                    clk_sb,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_level == '0);
  assign full      = (r_level == C_FULL_LVL);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign rdata     = r_mem[r_rd_ptr];
  assign level     = r_level;

  always_ff @(posedge clk_sb) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ws2812_tx.sv
// ============================================================================
// Module : ws2812_tx
// Buffers GRB pixel words and serialises them onto a WS2812 line with a latch
// gap after each frame. Optional status readback: define STATUS_READBACK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ws2812_tx
  import ws2812_pkg::*;
#(
  parameter int T0H_CYC    = DEF_T0H_CYC,
  parameter int T1H_CYC    = DEF_T1H_CYC,
  parameter int TBIT_CYC   = DEF_TBIT_CYC,
  parameter int TRST_CYC   = DEF_TRST_CYC,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk_sb,
  input  logic                          reset_n,
  input  logic                          rx_valid,
  input  logic [PIXEL_W-1:0]            rx_data,
  output logic                          led_dout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
`ifdef STATUS_READBACK_EN
  ,
  output logic                          status_tx,
  output logic [PIXEL_W-1:0]            status_data
`endif
);

  localparam int CW = $clog2(TRST_CYC + 1);
  localparam logic [CW-1:0] C_T0H_LAST  = CW'(T0H_CYC - 1);
  localparam logic [CW-1:0] C_T1H_LAST  = CW'(T1H_CYC - 1);
  localparam logic [CW-1:0] C_TBIT_LAST = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0] C_TRST_LAST = CW'(TRST_CYC - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_rx_prev;
  logic [CW-1:0]        r_cnt;
  logic [PIXEL_W-1:0]   r_shreg;
  logic [4:0]           r_bit_idx;
  logic                 r_led;
  logic                 r_overflow;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;
  logic [PIXEL_W-1:0]   w_fifo_rdata;
  logic [CW-1:0]        w_th_last;
  logic                 w_bit_end;
  logic                 w_frame_done;

  assign w_push    = rx_valid & ~r_rx_prev;
  assign w_drop    = w_push & w_full & ~w_pop;
  assign w_th_last = r_shreg[PIXEL_W-1] ? C_T1H_LAST : C_T0H_LAST;
  assign w_bit_end = (r_state == ST_LOW) && (r_cnt == C_TBIT_LAST);
  assign led_dout  = r_led;
  assign overflow  = r_overflow;

  ws2812_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sb  (clk_sb),
    .reset_n (reset_n),
    .push    (w_push),
    .wdata   (rx_data),
    .pop     (w_pop),
    .rdata   (w_fifo_rdata),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (!w_empty) w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = ST_HIGH;
      ST_HIGH:  if (r_cnt == w_th_last) w_state_next = ST_LOW;
      ST_LOW: begin
        if (w_bit_end) begin
          if (r_bit_idx != 5'd0 || !w_empty) w_state_next = ST_HIGH;
          else                               w_state_next = ST_LATCH;
        end
      end
      ST_LATCH: if (r_cnt == C_TRST_LAST) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // The reload on the final LOW cycle replaces LOAD so back-to-back words keep bit spacing.
  always_comb begin
    w_pop        = 1'b0;
    w_frame_done = 1'b0;
    busy         = (r_state != ST_IDLE);
    if (r_state == ST_LOAD) w_pop = 1'b1;
    if (w_bit_end && r_bit_idx == 5'd0) begin
      w_pop        = ~w_empty;
      w_frame_done = w_empty;
    end
  end

  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_prev  <= 1'b0;
      r_cnt      <= '0;
      r_shreg    <= '0;
      r_bit_idx  <= '0;
      r_led      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rx_prev  <= rx_valid;
      r_overflow <= w_drop;
      r_led      <= (w_state_next == ST_HIGH);
      // HIGH->LOW keeps counting so the bit total is measured from its start.
      if (r_state == ST_IDLE ||
          (w_state_next != r_state && w_state_next != ST_LOW))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CW'(1);
      if (w_pop) begin
        r_shreg   <= w_fifo_rdata;
        r_bit_idx <= 5'(PIXEL_W - 1);
      end else if (w_bit_end) begin
        r_shreg   <= {r_shreg[PIXEL_W-2:0], 1'b0};
        r_bit_idx <= r_bit_idx - 5'd1;
      end
    end
  end

`ifdef STATUS_READBACK_EN
  logic [7:0] r_ovf_cnt;
  logic [7:0] r_frame_cnt;
  logic       r_push_d;

  // The strobe trails the push by one cycle so the registered word already reflects it.
  always_ff @(posedge clk_sb or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf_cnt   <= '0;
      r_frame_cnt <= '0;
      r_push_d    <= 1'b0;
      status_tx   <= 1'b0;
      status_data <= '0;
    end else begin
      if (w_drop && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 8'd1;
      r_push_d  <= w_push;
      status_tx <= r_push_d;
      status_data[STAT_OVF_LSB +: 8] <= r_ovf_cnt;
      status_data[STAT_LVL_LSB +: 8] <= 8'(fifo_level);
      status_data[STAT_FRM_LSB +: 8] <= r_frame_cnt;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ws2812_tx.sv
// ============================================================================
// Module : tb_ws2812_tx
// Directed/randomised bench comparing led_dout pulse trains with a pulse model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ws2812_tx;

  localparam int T0H   = 16;
  localparam int T1H   = 34;
  localparam int TBIT  = 60;
  localparam int TRST  = 3000;
  localparam int DEPTH = 16;

  logic                      clk_sb = 1'b0;
  logic                      reset_n;
  logic                      rx_valid;
  logic [23:0]               rx_data;
  logic                      led_dout;
  logic                      busy;
  logic [$clog2(DEPTH):0]    fifo_level;
  logic                      overflow;
`ifdef STATUS_READBACK_EN
  logic                      status_tx;
  logic [23:0]               status_data;
`endif

  ws2812_tx #(
    .T0H_CYC    (T0H),
    .T1H_CYC    (T1H),
    .TBIT_CYC   (TBIT),
    .TRST_CYC   (TRST),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_sb      (clk_sb),
    .reset_n     (reset_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .led_dout    (led_dout),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
`ifdef STATUS_READBACK_EN
    ,
    .status_tx   (status_tx),
    .status_data (status_data)
`endif
  );

  always #5 clk_sb = ~clk_sb;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int rise_at = 0;
  int idle_cyc = 0;
  int ovf_hi  = 0;
  int st_hi   = 0;
  logic prev_led = 1'b0;

  int q_start[$];
  int q_width[$];
  int exp_w[$];
  bit exp_new[$];

  always @(posedge clk_sb) cyc <= cyc + 1;

  // Observed pulse train on the data line
  always @(negedge clk_sb) begin
    if (led_dout && !prev_led) rise_at = cyc;
    if (!led_dout && prev_led) begin
      q_start.push_back(rise_at);
      q_width.push_back(cyc - rise_at);
    end
    prev_led = led_dout;
    if (overflow) ovf_hi++;
`ifdef STATUS_READBACK_EN
    if (status_tx) st_hi++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Model: every pixel bit is one high pulse, MSB first, width by bit value.
  task automatic model_word(input logic [23:0] w, input bit new_frame);
    for (int b = 23; b >= 0; b--) begin
      exp_w.push_back(w[b] ? T1H : T0H);
      exp_new.push_back(new_frame && b == 23);
    end
  endtask

  task automatic clear_all();
    q_start.delete();
    q_width.delete();
    exp_w.delete();
    exp_new.delete();
    ovf_hi = 0;
    st_hi  = 0;
  endtask

  task automatic push_word(input logic [23:0] w, input int hold);
    @(negedge clk_sb);
    rx_data  = w;
    rx_valid = 1'b1;
    repeat (hold) @(negedge clk_sb);
    rx_valid = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string tag);
    int k = 0;
    while (q_width.size() < n && k < budget) begin
      @(negedge clk_sb);
      k++;
    end
    chk({tag, " pulse wait"}, q_width.size() >= n, 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while ((busy || fifo_level != 0) && k < budget) begin
      @(negedge clk_sb);
      k++;
    end
    idle_cyc = cyc;
    chk({tag, " idle wait"}, !busy && fifo_level == 0, 1);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, " pulse count"}, q_width.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < q_width.size(); i++) begin
      chk($sformatf("%s width[%0d]", tag, i), q_width[i], exp_w[i]);
      if (i > 0) begin
        if (exp_new[i])
          chk($sformatf("%s frame gap[%0d]", tag, i), (q_start[i] - q_start[i-1]) >= TBIT + TRST, 1);
        else
          chk($sformatf("%s period[%0d]", tag, i), q_start[i] - q_start[i-1], TBIT);
      end
    end
  endtask

  initial begin
    logic [23:0] w;
    int k;
    int last;

    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(negedge clk_sb);
    chk("reset led_dout", led_dout, 0);
    chk("reset busy", busy, 0);
    chk("reset fifo_level", fifo_level, 0);
    chk("reset overflow", overflow, 0);
`ifdef STATUS_READBACK_EN
    chk("reset status_tx", status_tx, 0);
    chk("reset status_data", status_data, 0);
`endif
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sb);

    // Single 0xFF0000 word; rx_valid held high must push once
    clear_all();
    rx_data  = 24'hFF0000;
    rx_valid = 1'b1;
    for (k = 1; k <= 8; k++) begin
      @(posedge clk_sb);
      #1;
      if (led_dout) break;
    end
    chk("first-bit latency", k, 3);
    repeat (5) @(negedge clk_sb);
    rx_valid = 1'b0;
    model_word(24'hFF0000, 1);
    wait_pulses(24, 24 * TBIT + 100, "single");
    wait_idle(TRST + 2 * TBIT, "single");
    check_stream("single");
    last = q_width.size() - 1;
    if (last >= 0)
      chk("single latch gap", (idle_cyc - (q_start[last] + q_width[last])) >= TRST, 1);
    chk("single no overflow", ovf_hi, 0);
`ifdef STATUS_READBACK_EN
    chk("single frame_cnt", status_data[7:0], 1);
`endif

    // Three words arriving during transmission form one contiguous frame
    clear_all();
    for (int i = 0; i < 3; i++) begin
      w = 24'($urandom());
      push_word(w, 1);
      model_word(w, i == 0);
      if (i < 2) repeat (200) @(negedge clk_sb);
    end
    wait_pulses(72, 72 * TBIT + 200, "triple");
    wait_idle(TRST + 2 * TBIT, "triple");
    check_stream("triple");

    // Fill FIFO during LATCH; 17th word is dropped
    clear_all();
    w = 24'($urandom());
    push_word(w, 1);
    model_word(w, 1);
    wait_pulses(24, 24 * TBIT + 100, "ovf first");
    repeat (TBIT) @(negedge clk_sb);
    chk("ovf in latch busy", busy, 1);
    for (int i = 0; i < 17; i++) begin
      w = 24'($urandom());
      push_word(w, 1);
      if (i < 16) model_word(w, i == 0);
      if (i == 15) begin
        repeat (2) @(negedge clk_sb);
        chk("ovf level full", fifo_level, 16);
        chk("ovf none yet", ovf_hi, 0);
        chk("ovf line low in latch", led_dout, 0);
      end
    end
    repeat (3) @(negedge clk_sb);
    chk("ovf one pulse", ovf_hi, 1);
    chk("ovf level held", fifo_level, 16);
`ifdef STATUS_READBACK_EN
    chk("ovf status strobes", st_hi, 17);
    chk("ovf status ovf_cnt", status_data[23:16], 1);
    chk("ovf status level", status_data[15:8], 32'(fifo_level));
`endif
    wait_pulses(24 + 384, 384 * TBIT + TRST + 500, "ovf");
    wait_idle(TRST + 2 * TBIT, "ovf");
    check_stream("ovf");

    // Word pushed during LATCH waits for the gap to expire
    clear_all();
    w = 24'($urandom());
    push_word(w, 1);
    model_word(w, 1);
    wait_pulses(24, 24 * TBIT + 100, "latch push first");
    repeat (TBIT + 20) @(negedge clk_sb);
    w = 24'($urandom());
    push_word(w, 1);
    model_word(w, 1);
    repeat (5) @(negedge clk_sb);
    chk("latch push line low", led_dout, 0);
    wait_pulses(48, TRST + 26 * TBIT, "latch push");
    wait_idle(TRST + 2 * TBIT, "latch push");
    check_stream("latch push");

    // Asynchronous reset during bit 10 of a word
    clear_all();
    push_word(24'($urandom()), 1);
    push_word(24'($urandom()), 1);
    wait_pulses(10, 12 * TBIT, "reset mid");
    k = 0;
    while (!led_dout && k < TBIT) begin
      @(negedge clk_sb);
      k++;
    end
    chk("reset mid line high", led_dout, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("reset mid led_dout", led_dout, 0);
    chk("reset mid fifo_level", fifo_level, 0);
    chk("reset mid busy", busy, 0);
`ifdef STATUS_READBACK_EN
    chk("reset mid status_data", status_data, 0);
`endif
    repeat (3) @(negedge clk_sb);
    reset_n = 1'b1;
    clear_all();
    w = 24'($urandom());
    push_word(w, 1);
    model_word(w, 1);
    wait_pulses(24, 24 * TBIT + 100, "after reset");
    wait_idle(TRST + 2 * TBIT, "after reset");
    check_stream("after reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
